// File: rtl/window_accumulator_if.sv
// Handshake bundle between a channel's sample source, the window accumulator
// and the downstream divider stage.
interface window_accumulator_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [2:0]       n_sel;
    logic             flush;
    logic             sum_valid;
    logic             sum_ready;
    logic [OUT_W-1:0] sum_out;
    logic [2:0]       n_out;
    logic             overflow;

    // Upstream source plus downstream sink, as seen from outside the block
    modport master (
        output in_valid, in_data, n_sel, flush, sum_ready,
        input  in_ready, sum_valid, sum_out, n_out, overflow
    );

    modport slave (
        input  in_valid, in_data, n_sel, flush, sum_ready,
        output in_ready, sum_valid, sum_out, n_out, overflow
    );
endinterface

// File: rtl/window_accumulator.sv
// Sums a window of 1..7 samples from one channel and hands the sum and window
// length to the divider stage over a valid/ready handshake.
module window_accumulator #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    window_accumulator_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state_q;
    logic [OUT_W-1:0] acc_q;
    logic [2:0]       count_q;
    logic [2:0]       n_lat_q;
    logic             ovf_win_q;
    logic             in_ready_q;
    logic             sum_valid_q;
    logic [OUT_W-1:0] sum_out_q;
    logic [2:0]       n_out_q;
    logic             overflow_q;

    logic             accept_s;
    logic [2:0]       n_first_s;
    logic [2:0]       n_eff_s;
    logic [OUT_W:0]   sum_wide_s;
    logic             sat_s;
    logic [OUT_W-1:0] acc_d;
    logic [2:0]       count_d;
    logic             ovf_win_d;
    logic             full_s;
    logic             emit_s;

    assign bus.in_ready  = in_ready_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_out   = sum_out_q;
    assign bus.n_out     = n_out_q;
    assign bus.overflow  = overflow_q;

    // Next accumulator/count values and the emit decision for this edge
    always_comb begin
        accept_s   = bus.in_valid && in_ready_q;
        n_first_s  = (bus.n_sel == 3'd0) ? 3'd1 : bus.n_sel;
        n_eff_s    = (count_q == 3'd0) ? n_first_s : n_lat_q;
        // One guard bit above OUT_W detects saturation of the running sum
        sum_wide_s = {1'b0, acc_q} + {{(OUT_W + 1 - IN_W){1'b0}}, bus.in_data};
        sat_s      = sum_wide_s[OUT_W];
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_win_d  = ovf_win_q;
        if (accept_s) begin
            acc_d     = sat_s ? {OUT_W{1'b1}} : sum_wide_s[OUT_W-1:0];
            count_d   = count_q + 3'd1;
            ovf_win_d = ovf_win_q | sat_s;
        end else begin
            acc_d     = acc_q;
            count_d   = count_q;
            ovf_win_d = ovf_win_q;
        end
        full_s = accept_s && (count_d == n_eff_s);
        emit_s = (state_q == ST_ACCUM) && (full_s || (bus.flush && (count_d != 3'd0)));
    end

    // Window FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {OUT_W{1'b0}};
            count_q     <= 3'd0;
            n_lat_q     <= 3'd1;
            ovf_win_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            sum_valid_q <= 1'b0;
            sum_out_q   <= {OUT_W{1'b0}};
            n_out_q     <= 3'd0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    acc_q     <= acc_d;
                    count_q   <= count_d;
                    ovf_win_q <= ovf_win_d;
                    if (accept_s && (count_q == 3'd0)) begin
                        n_lat_q <= n_first_s;
                    end
                    if (emit_s) begin
                        sum_out_q   <= acc_d;
                        n_out_q     <= count_d;
                        overflow_q  <= ovf_win_d;
                        sum_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Results stay frozen until the divider takes them
                    if (bus.sum_ready) begin
                        sum_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        acc_q       <= {OUT_W{1'b0}};
                        count_q     <= 3'd0;
                        ovf_win_q   <= 1'b0;
                        state_q     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q     <= ST_ACCUM;
                    acc_q       <= {OUT_W{1'b0}};
                    count_q     <= 3'd0;
                    ovf_win_q   <= 1'b0;
                    in_ready_q  <= 1'b1;
                    sum_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_window_accumulator.sv
// Directed bench for window_accumulator: a sample-list model checks every
// cycle, and literal expectations pin each window result.
module tb_window_accumulator;
    localparam int IN_W    = 12;
    localparam int OUT_W   = 16;
    localparam int SUM_MAX = (1 << OUT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    window_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    window_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: the open window is just a list of accepted samples
    int  m_win[$];
    int  m_n       = 1;
    bit  m_hold    = 1'b0;
    bit  m_rst_cyc = 1'b0;
    int  m_exp_sum = 0;
    int  m_exp_n   = 0;
    bit  m_exp_ovf = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int total;
        m_rst_cyc = 1'b0;
        if (rst) begin
            m_win.delete();
            m_n       = 1;
            m_hold    = 1'b0;
            m_rst_cyc = 1'b1;
        end else if (!m_hold) begin
            if (bus.in_valid) begin
                if (m_win.size() == 0) m_n = (bus.n_sel == 3'd0) ? 1 : int'(bus.n_sel);
                m_win.push_back(int'(bus.in_data));
            end
            if ((m_win.size() == m_n) || (bus.flush && m_win.size() > 0)) begin
                total = 0;
                foreach (m_win[i]) total += m_win[i];
                m_exp_ovf = (total > SUM_MAX);
                m_exp_sum = (total > SUM_MAX) ? SUM_MAX : total;
                m_exp_n   = m_win.size();
                m_hold    = 1'b1;
            end
        end else if (bus.sum_ready) begin
            m_hold = 1'b0;
            m_win.delete();
        end
        #1;
        chk("in_ready", bus.in_ready, !m_hold);
        chk("sum_valid", bus.sum_valid, m_hold);
        if (m_hold) begin
            chk("sum_out", bus.sum_out, m_exp_sum);
            chk("n_out", bus.n_out, m_exp_n);
            chk("overflow", bus.overflow, m_exp_ovf);
        end
        if (m_rst_cyc) begin
            chk("rst_sum_out", bus.sum_out, 0);
            chk("rst_n_out", bus.n_out, 0);
            chk("rst_overflow", bus.overflow, 0);
        end
    end

    task automatic put(input int d, input int ns, input bit fl);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(d);
        bus.n_sel    = 3'(ns);
        bus.flush    = fl;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.flush    = 1'b0;
        end
    endtask

    task automatic expect_win(input string nm, input int s, input int n, input bit o);
        int k = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        while (!bus.sum_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, bus.sum_valid, 1);
        chk({nm, "_sum"}, bus.sum_out, s);
        chk({nm, "_n"}, bus.n_out, n);
        chk({nm, "_ovf"}, bus.overflow, o);
        chk({nm, "_model"}, m_exp_sum, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.n_sel     = 3'd1;
        bus.flush     = 1'b0;
        bus.sum_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_sum_valid", bus.sum_valid, 0);
        idle(1);

        // Basic three-sample window, consumer always ready
        put(100, 3, 0); put(200, 3, 0); put(300, 3, 0);
        expect_win("w3", 600, 3, 0);
        @(negedge clk);
        chk("w3_ready_back", bus.in_ready, 1);
        idle(1);

        // Downstream stall keeps the result frozen
        bus.sum_ready = 1'b0;
        put(10, 2, 0); put(20, 2, 0);
        expect_win("stall", 30, 2, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_sum", bus.sum_out, 30);
            chk("stall_ready", bus.in_ready, 0);
        end
        bus.sum_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", bus.in_ready, 1);
        idle(1);

        // Flush with a same-cycle sample, then flush on an empty window
        put(5, 7, 0); put(6, 7, 0); put(7, 7, 1);
        expect_win("flush", 18, 3, 0);
        idle(2);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_empty", bus.sum_valid, 0);
        idle(1);

        // n_sel change mid-window is ignored until the next window
        put(1, 4, 0); put(2, 4, 0); put(3, 1, 0); put(4, 1, 0);
        expect_win("nchg", 10, 4, 0);
        idle(1);
        put(9, 1, 0);
        expect_win("nchg_next", 9, 1, 0);
        idle(1);

        // n_sel=0 means one sample; full-scale seven-sample window
        put(4095, 0, 0);
        expect_win("nsel0", 4095, 1, 0);
        idle(1);
        for (int i = 0; i < 7; i++) put(4095, 7, 0);
        expect_win("max", 28665, 7, 0);
        idle(1);

        // Reset in the middle of a window discards it
        put(1, 5, 0); put(1, 5, 0); put(1, 5, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", bus.sum_valid, 0);
        chk("midrst_sum", bus.sum_out, 0);
        chk("midrst_n", bus.n_out, 0);
        chk("midrst_ready", bus.in_ready, 1);
        idle(1);
        for (int i = 0; i < 5; i++) put(1, 5, 0);
        expect_win("after_rst", 5, 5, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
